lockin_quad_accumulator: RTL and testbench
==========================================

Name: lockin_quad_accumulator

Overview:
Quadrature-channel lock-in accumulator. It multiplies each ADC sample by the cosine (quadrature) reference and accumulates the products over one reference period. It scales and saturates each period sum to 32 bits and streams it as an Avalon-ST word into the downstream quadrature results FIFO (8192 x 32, read by the HPS over Avalon-MM). A start/done handshake bounds each capture to the FIFO depth, so the FIFO never overflows.

Parameters:
DATA_W, 16, signed ADC sample width
REF_W, 16, signed reference width
ACC_W, 48, signed accumulator width (must be >= DATA_W+REF_W+16)
MAX_RESULTS, 8192, maximum results per capture (equals downstream FIFO depth)

Ports:
clock  in  1  single system clock; all logic is on its rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse that starts a capture
samples_per_period  in  16  products per result; 0 is treated as 1
n_results  in  14  results per capture; values above MAX_RESULTS are clamped to MAX_RESULTS
shift  in  6  arithmetic right shift applied to the accumulator before saturation
adc_data  in  DATA_W  signed sample
adc_valid  in  1  sample qualifier
ref_q  in  REF_W  signed cosine reference, aligned with adc_data
avalonst_source_data  out  32  signed result to the FIFO sink data input
avalonst_source_valid  out  1  one-cycle write strobe to the FIFO sink valid input
busy  out  1  high while in RUN
done  out  1  high from capture end until the next start
result_count  out  14  results emitted in the current capture

Behaviour:
- Reset: the FSM goes to IDLE and all counters and pipeline registers clear. avalonst_source_data=0, avalonst_source_valid=0, busy=0, done=0, result_count=0. Reset asserted mid-capture aborts immediately; a partial period is never emitted.
- FSM states are IDLE, RUN and DONE.
  - IDLE -> RUN on start. Entering RUN latches samples_per_period, n_results and shift, and clears the accumulator, the sample counter and result_count.
  - If the latched n_results is 0, the FSM goes IDLE -> DONE directly and emits nothing.
  - RUN -> DONE in the cycle the n_results-th strobe is issued.
  - DONE -> RUN on start, re-latching everything. Otherwise DONE holds and done stays 1.
  - start during RUN is ignored.
- Pipeline, active only in RUN:
  - Stage 1: when adc_valid, register prod = adc_data*ref_q (signed, DATA_W+REF_W bits) together with a stage-1 valid bit.
  - Stage 2: when stage-1 valid, acc += sign-extended prod and the sample counter increments. On the last product of a period (counter = latched spp-1), stage 2 adds that final product, captures the period sum into the output stage, reloads acc to 0 and resets the counter to 0.
  - Stage 3: out = sat32(sum >>> shift). avalonst_source_valid pulses for exactly 1 cycle and result_count increments in the same cycle.
- Latency: the strobe appears 3 clocks after the adc_valid cycle of the period's last sample.
- Full throughput: one sample per clock, back-to-back periods, no bubbles.
- Saturation: a shifted value > 2^31-1 gives 0x7FFFFFFF; a value < -2^31 gives 0x80000000.
- Samples arriving after the final period's last sample are ignored. Products still in flight at the RUN -> DONE transition are discarded.
- Gaps in adc_valid are allowed: the counter advances only on valid samples.
- avalonst_source_data holds its last value between strobes.
- No backpressure: the FIFO has no ready signal, and n_results <= MAX_RESULTS guarantees no overflow as long as software drains the FIFO before the next start.

Optional Feature:
LOCKIN_SAT_FLAG_EN
- Defined: adds output port sat_flag (1 bit). It is set sticky when any emitted result was clamped, cleared on start and on reset.
- Undefined: no port and no logic; saturation behaviour is unchanged.

Test Plan:
1. spp=4, n_results=2, shift=0, adc=100, ref=2 every cycle -> two strobes, data=800 each. First strobe 3 clocks after the 4th sample, second exactly 4 clocks later. Then done=1, busy=0, result_count=2.
2. adc=-32768, ref=-32768, spp=4, shift=0 -> data=0x7FFFFFFF; sat_flag=1 when enabled. Same stimulus with shift=3 -> data=0x20000000, no saturation.
3. spp=0, n_results=1, adc=5, ref=3 -> one strobe, data=15 (treated as spp=1).
4. n_results=0 -> done=1 one cycle after start, no strobe. n_results=9000 -> exactly 8192 strobes.
5. adc_valid toggling 1-0-1-0 with spp=3, adc=1, ref=1 -> one result of 3, strobed 3 clocks after the 3rd valid sample. start pulsed during RUN -> no effect.
6. Assert reset in the middle of the 2nd period -> outputs are 0 within that cycle. After release, a new start gives result values uncontaminated by the aborted period.

Source files
------------

// File: rtl/lockin_quad_accumulator_if.sv
// Stream bundle for the lock-in accumulator: ADC/reference samples in,
// Avalon-ST result words out toward the quadrature results FIFO.
// master = sample producer / FIFO side, slave = accumulator.
interface lockin_quad_accumulator_if #(
    parameter int DATA_W = 16,
    parameter int REF_W  = 16
);
    logic signed [DATA_W-1:0] adc_data;
    logic                     adc_valid;
    logic signed [REF_W-1:0]  ref_q;
    logic signed [31:0]       avalonst_source_data;
    logic                     avalonst_source_valid;

    modport master (
        output adc_data, adc_valid, ref_q,
        input  avalonst_source_data, avalonst_source_valid
    );

    modport slave (
        input  adc_data, adc_valid, ref_q,
        output avalonst_source_data, avalonst_source_valid
    );
endinterface

// File: rtl/lockin_quad_accumulator.sv
// Quadrature lock-in accumulator: multiplies each sample by the cosine
// reference, sums one reference period, then scales/saturates the sum to a
// 32-bit Avalon-ST word. A capture is bounded to n_results words.
// Optional build macro LOCKIN_SAT_FLAG_EN adds a sticky sat_flag output.
module lockin_quad_accumulator #(
    parameter int DATA_W      = 16,
    parameter int REF_W       = 16,
    parameter int ACC_W       = 48,
    parameter int MAX_RESULTS = 8192
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] samples_per_period,
    input  logic [13:0] n_results,
    input  logic [5:0]  shift,
    lockin_quad_accumulator_if.slave st,
    output logic        busy,
    output logic        done,
    output logic [13:0] result_count
`ifdef LOCKIN_SAT_FLAG_EN
    ,
    output logic        sat_flag
`endif
);
    localparam int PROD_W = DATA_W + REF_W;
    localparam logic [13:0] MAX_N = 14'(MAX_RESULTS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;

    logic [15:0] spp_l;
    logic [13:0] n_l;
    logic [5:0]  shift_l;

    // A start is honoured whenever we are not already capturing.
    logic launch;
    assign launch = start && (state != RUN);

    logic [13:0] n_clamped;
    assign n_clamped = (n_results > MAX_N) ? MAX_N : n_results;

    logic signed [PROD_W-1:0] prod_q;
    logic                     s1_vld;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  sum_q;
    logic [15:0]              cnt_q;
    logic                     s2_vld;

    logic signed [ACC_W-1:0] prod_ext;
    assign prod_ext = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};

    // Scale the period sum and clamp it into the signed 32-bit range.
    logic signed [ACC_W-1:0] shifted;
    logic                    pos_ovf, neg_ovf;
    logic [31:0]             sat_val;
    always_comb begin
        shifted = sum_q >>> shift_l;
        pos_ovf = !shifted[ACC_W-1] && (|shifted[ACC_W-2:31]);
        neg_ovf = shifted[ACC_W-1] && !(&shifted[ACC_W-2:31]);
        sat_val = shifted[31:0];
        if (pos_ovf) sat_val = 32'h7FFF_FFFF;
        if (neg_ovf) sat_val = 32'h8000_0000;
    end

    // Capture control: latch parameters on start, finish on the last strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            spp_l   <= 16'd1;
            n_l     <= 14'd0;
            shift_l <= 6'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        spp_l   <= (samples_per_period == 16'd0) ? 16'd1 : samples_per_period;
                        n_l     <= n_clamped;
                        shift_l <= shift;
                        if (n_clamped == 14'd0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (s2_vld && (result_count == n_l - 14'd1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: register the sample-by-reference product.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prod_q <= '0;
            s1_vld <= 1'b0;
        end else if (state == RUN && st.adc_valid) begin
            prod_q <= st.adc_data * st.ref_q;
            s1_vld <= 1'b1;
        end else begin
            s1_vld <= 1'b0;
        end
    end

    // Stage 2: accumulate products; hand off the sum at the end of each period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            sum_q  <= '0;
            cnt_q  <= 16'd0;
            s2_vld <= 1'b0;
        end else if (launch) begin
            acc_q  <= '0;
            cnt_q  <= 16'd0;
            s2_vld <= 1'b0;
        end else if (state == RUN && s1_vld) begin
            if (cnt_q == spp_l - 16'd1) begin
                sum_q  <= acc_q + prod_ext;
                acc_q  <= '0;
                cnt_q  <= 16'd0;
                s2_vld <= 1'b1;
            end else begin
                acc_q  <= acc_q + prod_ext;
                cnt_q  <= cnt_q + 16'd1;
                s2_vld <= 1'b0;
            end
        end else begin
            s2_vld <= 1'b0;
        end
    end

    // Stage 3: emit the saturated word as a one-cycle strobe; data holds after.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st.avalonst_source_data  <= '0;
            st.avalonst_source_valid <= 1'b0;
            result_count             <= 14'd0;
        end else if (launch) begin
            st.avalonst_source_valid <= 1'b0;
            result_count             <= 14'd0;
        end else if (state == RUN && s2_vld) begin
            st.avalonst_source_data  <= sat_val;
            st.avalonst_source_valid <= 1'b1;
            result_count             <= result_count + 14'd1;
        end else begin
            st.avalonst_source_valid <= 1'b0;
        end
    end

`ifdef LOCKIN_SAT_FLAG_EN
    // Sticky record that some emitted word was clamped during this capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            sat_flag <= 1'b0;
        else if (launch)
            sat_flag <= 1'b0;
        else if (state == RUN && s2_vld && (pos_ovf || neg_ovf))
            sat_flag <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_lockin_quad_accumulator.sv
// Bench for lockin_quad_accumulator: directed captures, a period-sum model
// predicting every strobe (value, cycle, count), plus literal spot checks.
module tb_lockin_quad_accumulator;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] samples_per_period = 16'd0;
    logic [13:0] n_results = 14'd0;
    logic [5:0]  shift = 6'd0;
    logic        busy, done;
    logic [13:0] result_count;
`ifdef LOCKIN_SAT_FLAG_EN
    logic        sat_flag;
`endif

    lockin_quad_accumulator_if #(.DATA_W(16), .REF_W(16)) st_if ();

    lockin_quad_accumulator dut (
        .clock(clock), .reset(reset), .start(start),
        .samples_per_period(samples_per_period), .n_results(n_results), .shift(shift),
        .st(st_if.slave), .busy(busy), .done(done), .result_count(result_count)
`ifdef LOCKIN_SAT_FLAG_EN
        , .sat_flag(sat_flag)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a capture is a list of products cut into periods of spp.
    typedef struct {logic [31:0] val; int at; int idx;} exp_t;
    exp_t exp_q[$];
    bit     m_active = 0;
    int     m_run_end = -10;
    int     m_spp, m_n, m_shift, m_cnt, m_emitted;
    longint m_acc;

    function automatic logic [31:0] sat32(input longint s);
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        return s[31:0];
    endfunction

    task automatic model_start(input int spp, input int n, input int sh);
        if (m_active || (cyc + 1 <= m_run_end)) return;
        m_spp = (spp == 0) ? 1 : spp;
        m_n = (n > 8192) ? 8192 : n;
        m_shift = sh;
        m_cnt = 0; m_acc = 0; m_emitted = 0;
        m_active = (m_n != 0);
    endtask

    task automatic model_sample(input int a, input int r);
        exp_t e;
        if (!m_active) return;
        m_acc += longint'(a) * longint'(r);
        m_cnt++;
        if (m_cnt == m_spp) begin
            e.val = sat32(m_acc >>> m_shift);
            e.at = cyc + 3;
            e.idx = m_emitted;
            exp_q.push_back(e);
            m_emitted++;
            m_acc = 0; m_cnt = 0;
            if (m_emitted == m_n) begin
                m_active = 0;
                m_run_end = cyc + 3;
            end
        end
    endtask

    // Compare process: every strobe must match the model's next word.
    int strobe_cyc[$];
    always @(negedge clock) begin
        logic [31:0] d;
        exp_t e;
        if (!reset) begin
            if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                check("missing_strobe", 0, 1);
                void'(exp_q.pop_front());
            end
            if (st_if.avalonst_source_valid) begin
                strobe_cyc.push_back(cyc);
                d = st_if.avalonst_source_data;
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", longint'(d), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_data", longint'(d), longint'(e.val));
                    check("strobe_cycle", cyc, e.at);
                    check("strobe_count", result_count, e.idx + 1);
                end
            end
        end
    end

    task automatic cyc_drive(input bit v, input int a, input int r);
        @(posedge clock); #1;
        start = 1'b0;
        st_if.adc_valid = v;
        st_if.adc_data = 16'(a);
        st_if.ref_q = 16'(r);
        if (v) model_sample(a, r);
    endtask

    task automatic do_start(input int spp, input int n, input int sh);
        @(posedge clock); #1;
        start = 1'b1;
        samples_per_period = 16'(spp);
        n_results = 14'(n);
        shift = 6'(sh);
        st_if.adc_valid = 1'b0;
        model_start(spp, n, sh);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc_drive(0, 0, 0);
    endtask

    int base, c_last;

    initial begin
        st_if.adc_valid = 1'b0;
        st_if.adc_data = '0;
        st_if.ref_q = '0;
        #1;
        check("rst_data", longint'(st_if.avalonst_source_data), 0);
        check("rst_valid", st_if.avalonst_source_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", result_count, 0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // 1: two periods of 100*2*4 = 800, strobes 4 clocks apart
        base = strobe_cyc.size();
        do_start(4, 2, 0);
        for (int i = 0; i < 8; i++) begin
            cyc_drive(1, 100, 2);
            if (i == 3) c_last = cyc;
        end
        @(negedge clock);
        check("t1_busy_running", busy, 1);
        idle(6);
        @(negedge clock);
        check("t1_data", longint'(st_if.avalonst_source_data), 800);
        check("t1_n_strobes", strobe_cyc.size() - base, 2);
        if (strobe_cyc.size() - base == 2) begin
            check("t1_first_latency", strobe_cyc[base], c_last + 3);
            check("t1_spacing", strobe_cyc[base+1] - strobe_cyc[base], 4);
        end
        check("t1_done", done, 1);
        check("t1_busy", busy, 0);
        check("t1_count", result_count, 2);

        // 2: 4 * 2^30 saturates unshifted, fits after >>> 3
        do_start(4, 1, 0);
        for (int i = 0; i < 4; i++) cyc_drive(1, -32768, -32768);
        idle(5);
        @(negedge clock);
        check("t2_sat_data", longint'(st_if.avalonst_source_data), 32'h7FFF_FFFF);
`ifdef LOCKIN_SAT_FLAG_EN
        check("t2_sat_flag", sat_flag, 1);
`endif
        do_start(4, 1, 3);
        for (int i = 0; i < 4; i++) cyc_drive(1, -32768, -32768);
        idle(5);
        @(negedge clock);
        check("t2_shift_data", longint'(st_if.avalonst_source_data), 32'h2000_0000);
`ifdef LOCKIN_SAT_FLAG_EN
        check("t2_no_sat_flag", sat_flag, 0);
`endif

        // 3: spp=0 behaves as 1
        base = strobe_cyc.size();
        do_start(0, 1, 0);
        cyc_drive(1, 5, 3);
        idle(5);
        @(negedge clock);
        check("t3_data", longint'(st_if.avalonst_source_data), 15);
        check("t3_n_strobes", strobe_cyc.size() - base, 1);

        // 4a: n_results=0 -> done next cycle, nothing emitted
        base = strobe_cyc.size();
        do_start(4, 0, 0);
        cyc_drive(1, 9, 9);
        @(negedge clock);
        check("t4_done_next", done, 1);
        check("t4_busy", busy, 0);
        for (int i = 0; i < 8; i++) cyc_drive(1, 9, 9);
        idle(4);
        check("t4_no_strobe", strobe_cyc.size() - base, 0);
        check("t4_count0", result_count, 0);

        // 4b: n_results above depth clamps to 8192
        base = strobe_cyc.size();
        do_start(1, 9000, 0);
        for (int i = 0; i < 8200; i++) cyc_drive(1, 1, 1);
        idle(5);
        @(negedge clock);
        check("t4_clamp_strobes", strobe_cyc.size() - base, 8192);
        check("t4_clamp_count", result_count, 8192);
        check("t4_clamp_done", done, 1);

        // 5: gapped valid, start during RUN ignored
        base = strobe_cyc.size();
        do_start(3, 1, 0);
        cyc_drive(1, 1, 1);
        cyc_drive(0, 0, 0);
        cyc_drive(1, 1, 1);
        cyc_drive(0, 0, 0);
        do_start(1, 5, 0);
        cyc_drive(1, 1, 1);
        c_last = cyc;
        idle(6);
        @(negedge clock);
        check("t5_data", longint'(st_if.avalonst_source_data), 3);
        check("t5_n_strobes", strobe_cyc.size() - base, 1);
        if (strobe_cyc.size() - base == 1)
            check("t5_latency", strobe_cyc[base], c_last + 3);
        check("t5_count", result_count, 1);
        check("t5_done", done, 1);

        // 6: reset mid second period, then a clean capture
        do_start(4, 3, 0);
        for (int i = 0; i < 7; i++) cyc_drive(1, 7, 7);
        @(posedge clock); #1;
        reset = 1'b1;
        st_if.adc_valid = 1'b0;
        exp_q.delete();
        m_active = 0;
        m_run_end = -10;
        #1;
        check("t6_rst_data", longint'(st_if.avalonst_source_data), 0);
        check("t6_rst_valid", st_if.avalonst_source_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_count", result_count, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        base = strobe_cyc.size();
        do_start(2, 2, 0);
        for (int i = 0; i < 4; i++) cyc_drive(1, 3, 4);
        idle(6);
        @(negedge clock);
        check("t6_data", longint'(st_if.avalonst_source_data), 24);
        check("t6_n_strobes", strobe_cyc.size() - base, 2);
        check("t6_count", result_count, 2);
        check("t6_model_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
